// File: rtl/wave_pkg.sv
// wave_pkg: shared state encoding and default widths for the waveform datapath
package wave_pkg;
  typedef enum logic {ST_IDLE, ST_RUN} state_t;
  localparam int ADDR_W = 10;
  localparam int PHASE_W = 16;
endpackage

// File: rtl/rate_divider.sv
// rate_divider: loadable modulo-P counter whose registered strobe marks count P-1
module rate_divider #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] period_i,
  output logic             tc_o
);
  logic [DIV_W-1:0] per_q, per_d, cnt_q, cnt_d;
  logic tc_q, tc_d;
  // strobe is precomputed from next count so it is high exactly while count is P-1
  always_comb begin
    per_d = clr_i ? (period_i == '0 ? DIV_W'(1) : period_i) : per_q;
    cnt_d = clr_i ? '0 : en_i ? (cnt_q == per_q - DIV_W'(1) ? '0 : cnt_q + DIV_W'(1)) : cnt_q;
    tc_d = (clr_i | en_i) & (cnt_d == per_d - DIV_W'(1));
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      per_q <= DIV_W'(1);
      cnt_q <= '0;
      tc_q <= 1'b0;
    end else begin
      per_q <= per_d;
      cnt_q <= cnt_d;
      tc_q <= tc_d;
    end
  end
  assign tc_o = tc_q;
endmodule

// File: rtl/sample_sequencer.sv
// sample_sequencer: start/stop playback FSM with phase accumulator and burst counter
module sample_sequencer #(
  parameter int DIV_W = 16,
  parameter int ADDR_W = wave_pkg::ADDR_W,
  parameter int PHASE_W = wave_pkg::PHASE_W,
  parameter int CNT_W = 16
) (
  input  logic               CLOCK_50,
  input  logic               RESET,
  input  logic               start,
  input  logic               stop,
  input  logic [DIV_W-1:0]   div_period,
  input  logic [PHASE_W-1:0] phase_inc,
  input  logic [CNT_W-1:0]   burst_len,
  output logic [ADDR_W-1:0]  addr,
  output logic               load,
  output logic               busy,
  output logic               done
);
  import wave_pkg::*;
  state_t state_q, state_d;
  logic [PHASE_W-1:0] phase_q, phase_d, inc_q, inc_d;
  logic [CNT_W-1:0] len_q, len_d, scnt_q, scnt_d;
  logic done_q, done_d, go, last, load_w;
  // the final burst load leaves the phase untouched so addr holds its last value
  always_comb begin
    go = state_q == ST_IDLE && start && !stop;
    last = load_w && len_q != '0 && scnt_q == len_q - CNT_W'(1);
    state_d = go ? ST_RUN : (state_q == ST_RUN && (stop || last)) ? ST_IDLE : state_q;
    done_d = state_q == ST_RUN && last && !stop;
    inc_d = go ? phase_inc : inc_q;
    len_d = go ? burst_len : len_q;
    phase_d = go ? '0 : (load_w && !last) ? phase_q + inc_q : phase_q;
    scnt_d = go ? '0 : load_w ? scnt_q + CNT_W'(1) : scnt_q;
  end
  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      inc_q <= '0;
      len_q <= '0;
      scnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      inc_q <= inc_d;
      len_q <= len_d;
      scnt_q <= scnt_d;
      done_q <= done_d;
    end
  end
  rate_divider #(.DIV_W(DIV_W)) u_div (
    .clk      (CLOCK_50),
    .rst      (RESET),
    .clr_i    (go),
    .en_i     (state_d == ST_RUN && !go),
    .period_i (div_period),
    .tc_o     (load_w)
  );
  assign addr = phase_q[PHASE_W-1 -: ADDR_W];
  assign load = load_w;
  assign busy = state_q == ST_RUN;
  assign done = done_q;
endmodule

// File: tb/tb_sample_sequencer.sv
// tb_sample_sequencer: directed checks of bursts, wrap, stop, ignored events and reset
module tb_sample_sequencer;
  logic clk = 1'b0;
  logic rst, start, stop, load, busy, done;
  logic [15:0] div_period, phase_inc, burst_len;
  logic [9:0] addr;
  int n_chk = 0;
  int n_pass = 0;

  sample_sequencer dut (
    .CLOCK_50   (clk),
    .RESET      (rst),
    .start      (start),
    .stop       (stop),
    .div_period (div_period),
    .phase_inc  (phase_inc),
    .burst_len  (burst_len),
    .addr       (addr),
    .load       (load),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic kick(input logic [15:0] p, input logic [15:0] inc, input logic [15:0] n);
    div_period = p;
    phase_inc = inc;
    burst_len = n;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle_check(input string tag, input int cycles);
    for (int k = 0; k < cycles; k++) begin
      chk({tag, "_load"}, 32'(load), 0);
      chk({tag, "_busy"}, 32'(busy), 0);
      tick();
    end
  endtask

  logic [9:0] frac_addr [4] = '{10'd0, 10'd0, 10'd1, 10'd1};

  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    div_period = 16'd4;
    phase_inc = 16'h0040;
    burst_len = 16'd5;
    tick();
    chk("rst_addr", 32'(addr), 0);
    chk("rst_load", 32'(load), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    rst = 1'b0;
    idle_check("post_rst", 3);

    // burst P=4, N=5
    kick(16'd4, 16'h0040, 16'd5);
    for (int k = 1; k <= 23; k++) begin
      chk($sformatf("burst_busy%0d", k), 32'(busy), 32'(k <= 20));
      chk($sformatf("burst_load%0d", k), 32'(load), 32'(k <= 20 && k % 4 == 0));
      chk($sformatf("burst_done%0d", k), 32'(done), 32'(k == 21));
      if (k % 4 == 0 && k <= 20) chk($sformatf("burst_addr%0d", k), 32'(addr), 32'(k / 4 - 1));
      if (k > 20) chk($sformatf("burst_hold%0d", k), 32'(addr), 4);
      tick();
    end

    // P=0 treated as 1, wrapping accumulator, continuous
    kick(16'd0, 16'h4000, 16'd0);
    for (int k = 1; k <= 7; k++) begin
      chk($sformatf("wrap_load%0d", k), 32'(load), 1);
      chk($sformatf("wrap_addr%0d", k), 32'(addr), 32'(((k - 1) * 256) % 1024));
      if (k == 7) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    chk("wrap_stop_done", 32'(done), 0);
    idle_check("wrap_stop", 3);

    // fractional step P=2, N=4
    kick(16'd2, 16'h0020, 16'd4);
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("frac_load%0d", k), 32'(load), 32'(k <= 8 && k % 2 == 0));
      chk($sformatf("frac_done%0d", k), 32'(done), 32'(k == 9));
      if (k <= 8 && k % 2 == 0) chk($sformatf("frac_addr%0d", k), 32'(addr), 32'(frac_addr[k / 2 - 1]));
      tick();
    end

    // stop coinciding with the second load, continuous P=3
    kick(16'd3, 16'h0040, 16'd0);
    for (int k = 1; k <= 6; k++) begin
      chk($sformatf("stop_load%0d", k), 32'(load), 32'(k % 3 == 0));
      chk($sformatf("stop_busy%0d", k), 32'(busy), 1);
      if (k == 6) stop = 1'b1;
      tick();
    end
    stop = 1'b0;
    chk("stop_done", 32'(done), 0);
    idle_check("stop_after", 6);

    // start and stop together in IDLE
    div_period = 16'd1;
    stop = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    stop = 1'b0;
    idle_check("both", 3);

    // start during RUN is ignored
    kick(16'd1, 16'h0040, 16'd0);
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("ign_load%0d", k), 32'(load), 1);
      chk($sformatf("ign_addr%0d", k), 32'(addr), 32'(k - 1));
      if (k == 2) begin
        start = 1'b1;
        phase_inc = 16'h4000;
        div_period = 16'd5;
      end else start = 1'b0;
      tick();
    end
    start = 1'b0;

    // asynchronous reset in the middle of a load cycle
    #3;
    rst = 1'b1;
    #1;
    chk("arst_load", 32'(load), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_addr", 32'(addr), 0);
    chk("arst_done", 32'(done), 0);
    tick();
    rst = 1'b0;
    idle_check("arst_after", 4);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
